// File: rtl/load_fmap_pingpong.sv
// Ping-pong feature-map loader: two scratchpad banks, one filled from a
// valid/ready beat stream while the PE array reads the other. Supports
// full-frame and column-incremental fills with explicit PE-side release.
module load_fmap_pingpong #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_NUM     = 2,
    parameter int ADDR_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_start,
    input  logic                         load_full_column,
    input  logic [ADDR_W:0]              pixel_num,
    input  logic [ADDR_W:0]              col_num,
    input  logic [DATA_WIDTH*CH_NUM-1:0] fmap_in_data,
    input  logic                         fmap_in_valid,
    output logic                         fmap_in_ready,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [DATA_WIDTH*CH_NUM-1:0] rd_data,
    input  logic                         pe_release,
    output logic                         bank_ready,
    output logic                         rd_bank,
    output logic [ADDR_W:0]              col_ptr,
    output logic                         load_busy,
    output logic                         load_done,
    output logic                         load_err
);

    localparam int WORD_W = DATA_WIDTH * CH_NUM;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BANK,
        S_LOAD
    } state_e;

    state_e              state_q, state_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [1:0]          bank_full_q, bank_full_d;
    logic [ADDR_W:0]     col_ptr_q, col_ptr_d;
    logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
    logic [ADDR_W+1:0]   end_q, end_d;
    logic [ADDR_W:0]     pix_q, pix_d;
    logic                full_mode_q, full_mode_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;
    logic [WORD_W-1:0]   rd_data_q;

    // Both banks live in one array; the bank select is the address MSB.
    logic [WORD_W-1:0]   bank_mem [2*DEPTH];

    logic [ADDR_W+1:0]   cmd_end;
    logic                cmd_err;
    logic                beat_fire;
    logic                last_beat;
    logic                release_ok;

    // Command decode: end address is one bit wider so a column overrun is
    // detected rather than wrapped.
    assign cmd_end   = load_full_column ? {1'b0, pixel_num}
                                        : {1'b0, col_ptr_q} + {1'b0, col_num};
    assign cmd_err   = (pixel_num == '0) ||
                       (!load_full_column && ((col_num == '0) || (cmd_end > {1'b0, pixel_num})));
    assign beat_fire  = (state_q == S_LOAD) && fmap_in_valid;
    assign last_beat  = beat_fire && (({1'b0, wr_addr_q} + (ADDR_W+2)'(1)) == end_q);
    assign release_ok = pe_release && bank_full_q[rd_bank_q];

    // Next-state logic for the load FSM, bank bookkeeping and status pulses.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can leave it unassigned and infer a latch.
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        col_ptr_d   = col_ptr_q;
        wr_addr_d   = wr_addr_q;
        end_d       = end_q;
        pix_d       = pix_q;
        full_mode_d = full_mode_q;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    if (cmd_err) begin
                        load_err_d = 1'b1;
                    end else begin
                        full_mode_d = load_full_column;
                        end_d       = cmd_end;
                        pix_d       = pixel_num;
                        wr_addr_d   = load_full_column ? '0 : col_ptr_q;
                        state_d     = bank_full_q[wr_bank_q] ? S_WAIT_BANK : S_LOAD;
                    end
                end
            end
            S_WAIT_BANK: begin
                if (!bank_full_q[wr_bank_q]) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (beat_fire) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (last_beat) begin
                        state_d     = S_IDLE;
                        load_done_d = 1'b1;
                        if (full_mode_q || (end_q == {1'b0, pix_q})) begin
                            bank_full_d[wr_bank_q] = 1'b1;
                            wr_bank_d              = ~wr_bank_q;
                            col_ptr_d              = '0;
                        end else begin
                            col_ptr_d = end_q[ADDR_W:0];
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion always targets wr_bank, release always targets the full
        // rd_bank; they never collide, so both updates apply.
        if (release_ok) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            col_ptr_q   <= '0;
            wr_addr_q   <= '0;
            end_q       <= '0;
            pix_q       <= '0;
            full_mode_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            col_ptr_q   <= col_ptr_d;
            wr_addr_q   <= wr_addr_d;
            end_q       <= end_d;
            pix_q       <= pix_d;
            full_mode_q <= full_mode_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // Bank write port: one beat per accepted handshake.
    // NOTE: the storage array has no reset; bank_full gates its logical validity, which keeps it mappable to SRAM.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            bank_mem[{wr_bank_q, wr_addr_q[ADDR_W-1:0]}] <= fmap_in_data;
        end
    end

    // PE read port: one-cycle latency, holds when rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= bank_mem[{rd_bank_q, rd_addr}];
        end
    end

    assign fmap_in_ready = (state_q == S_LOAD);
    assign load_busy     = (state_q != S_IDLE);
    assign bank_ready    = bank_full_q[rd_bank_q];
    assign rd_bank       = rd_bank_q;
    assign col_ptr       = col_ptr_q;
    assign load_done     = load_done_q;
    assign load_err      = load_err_q;
    assign rd_data       = rd_data_q;

endmodule

// File: doc/load_fmap_pingpong.md
Name: load_fmap_pingpong

Overview:
Parametrised successor to the single-pad fmap loader. It keeps two scratchpad banks so the loader fills one bank while the PE array reads the other. It accepts CH_NUM feature channels per beat over a valid/ready stream. It supports full-frame and column-incremental fill modes, with explicit bank release from the PE side.

Parameters:
DATA_WIDTH, 16, width of one channel sample
CH_NUM, 2, channels packed per beat/word (word width = DATA_WIDTH*CH_NUM)
ADDR_W, 8, bank address width; each bank is 2^ADDR_W words

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
load_start  input  1  start one load command (sampled in IDLE only)
load_full_column  input  1  1 = full-frame mode, 0 = column mode (sampled with load_start)
pixel_num  input  ADDR_W+1  words per complete bank (1..2^ADDR_W)
col_num  input  ADDR_W+1  words per column command (column mode)
fmap_in_data  input  DATA_WIDTH*CH_NUM  input beat
fmap_in_valid  input  1  beat valid
fmap_in_ready  output  1  loader accepts beat
rd_en  input  1  PE read strobe
rd_addr  input  ADDR_W  PE read address within rd_bank
rd_data  output  DATA_WIDTH*CH_NUM  registered read data
pe_release  input  1  PE finished with rd_bank
bank_ready  output  1  rd_bank holds a complete frame
rd_bank  output  1  bank currently presented to PE
col_ptr  output  ADDR_W+1  next column start address in wr_bank
load_busy  output  1  FSM not IDLE
load_done  output  1  one-cycle pulse after last beat of a command
load_err  output  1  one-cycle pulse on illegal command

Behaviour:
- Reset: all outputs 0. Internal state: FSM=IDLE, wr_bank=0, rd_bank=0, bank_full=2'b00, col_ptr=0. Memory contents are not reset.
- FSM states: IDLE, WAIT_BANK, LOAD.
- IDLE, on load_start:
  - Full mode: start=0, end=pixel_num.
  - Column mode: start=col_ptr, end=col_ptr+col_num, computed at ADDR_W+2 bits, no wrap.
  - Error if pixel_num==0, or column mode with col_num==0 or end>pixel_num. On error: load_err=1 next cycle, stay in IDLE, no other state change.
  - Otherwise latch start/end/mode and set wr_addr=start. Go to WAIT_BANK if bank_full[wr_bank], else LOAD.
- load_start outside IDLE is ignored. load_busy = (FSM!=IDLE).
- WAIT_BANK: fmap_in_ready=0. Go to LOAD on the cycle after bank_full[wr_bank] clears.
- LOAD:
  - fmap_in_ready=1 (combinational from state).
  - Each cycle with valid&ready: write the beat to bank[wr_bank][wr_addr], then wr_addr+1.
  - On the beat with wr_addr==end-1: next cycle load_done=1, FSM=IDLE.
  - Completion: if the mode is full, or end==pixel_num, then bank_full[wr_bank]<=1, wr_bank toggles, col_ptr<=0. Otherwise col_ptr<=end.
  - Full mode always leaves col_ptr=0.
- Bank release:
  - bank_ready = bank_full[rd_bank].
  - pe_release with bank_ready=1: clear bank_full[rd_bank] and toggle rd_bank, effective next cycle.
  - pe_release with bank_ready=0 is ignored.
  - Completion and release in the same cycle always target different banks; both take effect.
- Read path:
  - rd_en=1: rd_data <= bank[rd_bank][rd_addr] at the next edge (latency 1).
  - rd_en=0: rd_data holds.
  - Reads are allowed when bank_ready=0; the data is undefined.
- Writes never target rd_bank while it is full, so there is no read/write collision.
- Throughput: one beat per cycle in LOAD with valid held high. The command-to-first-ready gap is 1 cycle (IDLE→LOAD).
- Asserting rst_n low mid-load aborts immediately. After release the block starts empty; partial data is discarded logically.

Test Plan:
1. Full mode, pixel_num=16, 16 back-to-back beats (values 0..15):
   - load_done pulses the cycle after beat 15; bank_ready=1, rd_bank=0, wr_bank=1.
   - rd_addr 0..15 returns 0..15 with 1-cycle latency.
2. Column mode, pixel_num=12, col_num=4, three commands:
   - col_ptr goes 4, 8, then 0.
   - bank_ready rises only after the third load_done.
   - Data lands at addresses 0..11 in order.
3. Ping-pong: fill bank0, fill bank1 while reading bank0, then issue a third load_start:
   - FSM enters WAIT_BANK with fmap_in_ready=0.
   - pe_release moves rd_bank to 1; LOAD begins 1 cycle after bank0 clears.
   - The third frame is written into bank0.
4. Errors:
   - pixel_num=0 → load_err pulse, load_busy stays 0.
   - Column mode with col_ptr=8, col_num=8, pixel_num=12 → load_err, col_ptr unchanged at 8.
5. Valid gaps: fmap_in_valid toggled 1-0-1 over 8 beats → exactly 8 writes, addresses contiguous, load_done once.
6. Reset mid-LOAD after 5 of 16 beats:
   - All outputs 0, bank_ready=0, col_ptr=0.
   - A subsequent full load of 16 completes normally.
